// File: rtl/ahb_cmd_master_if.sv
// Command/response and AHB-Lite bus bundle for ahb_cmd_master.
// The master modport is the initiator's view; slave is the bus/command-source view.
interface ahb_cmd_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [1:0]            cmd_size;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_err;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic                  HMASTLOCK;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
        input  cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_err, rsp_rdata,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_err, rsp_rdata,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_cmd_master.sv
// Pipelined AHB-Lite initiator: one register command per single transfer, one address
// phase overlapping one data phase, with wait-state and two-cycle ERROR handling.
module ahb_cmd_master #(
    parameter int          ADDR_WIDTH      = 32,
    parameter int          DATA_WIDTH      = 32,
    parameter int          REPLAY_ON_ERROR = 1,
    parameter logic [3:0]  HPROT_VAL       = 4'b0011
) (
    input  logic              HCLK,
    input  logic              HRESET,
    ahb_cmd_master_if.master  bus
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam bit         REPLAY_EN     = (REPLAY_ON_ERROR != 0);

    function automatic logic [1:0] norm_size(input logic [1:0] size);
        case (size)
            2'd3:    norm_size = 2'd2;
            default: norm_size = size;
        endcase
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] align_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                         input logic [1:0]            size);
        logic [ADDR_WIDTH-1:0] a;
        a = addr;
        case (size)
            2'd1:    a[0]   = 1'b0;
            2'd2:    a[1:0] = 2'b00;
            default: a      = addr;
        endcase
        return a;
    endfunction

    logic                  addr_valid_r;
    logic                  addr_write_r;
    logic [1:0]            addr_size_r;
    logic [ADDR_WIDTH-1:0] haddr_r;
    logic [DATA_WIDTH-1:0] addr_wdata_r;

    logic                  data_valid_r;
    logic                  data_write_r;
    logic [DATA_WIDTH-1:0] hwdata_r;

    logic                  replay_pending_r;
    logic                  replay_in_addr_r;
    logic                  rp_write_r;
    logic [1:0]            rp_size_r;
    logic [ADDR_WIDTH-1:0] rp_addr_r;
    logic [DATA_WIDTH-1:0] rp_wdata_r;

    logic                  cancel_pending_r;
    logic                  rsp_valid_r;
    logic                  rsp_err_r;
    logic [DATA_WIDTH-1:0] rsp_rdata_r;

    logic err1_s;
    logic addr_free_s;
    logic cmd_ready_s;
    logic accept_s;
    logic issue_replay_s;
    logic cancel_set_s;

    // Handshake and pipeline-advance decode; the first ERROR cycle freezes acceptance.
    always_comb begin
        err1_s         = bus.HRESP & ~bus.HREADY;
        addr_free_s    = ~addr_valid_r | bus.HREADY;
        cmd_ready_s    = ~HRESET & ~replay_pending_r & addr_free_s & ~err1_s;
        accept_s       = bus.cmd_valid & cmd_ready_s;
        issue_replay_s = replay_pending_r & ~replay_in_addr_r & addr_free_s & ~err1_s;
        cancel_set_s   = err1_s & addr_valid_r & ~REPLAY_EN;
    end

    // Address phase register and replay slot.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_valid_r     <= 1'b0;
            addr_write_r     <= 1'b0;
            addr_size_r      <= 2'd0;
            haddr_r          <= {ADDR_WIDTH{1'b0}};
            addr_wdata_r     <= {DATA_WIDTH{1'b0}};
            replay_pending_r <= 1'b0;
            replay_in_addr_r <= 1'b0;
            rp_write_r       <= 1'b0;
            rp_size_r        <= 2'd0;
            rp_addr_r        <= {ADDR_WIDTH{1'b0}};
            rp_wdata_r       <= {DATA_WIDTH{1'b0}};
        end else if (err1_s) begin
            // The pending NONSEQ is withdrawn; keep a copy when it is to be re-issued.
            if (addr_valid_r) begin
                addr_valid_r <= 1'b0;
                if (REPLAY_EN) begin
                    replay_pending_r <= 1'b1;
                    replay_in_addr_r <= 1'b0;
                    rp_write_r       <= addr_write_r;
                    rp_size_r        <= addr_size_r;
                    rp_addr_r        <= haddr_r;
                    rp_wdata_r       <= addr_wdata_r;
                end
            end
        end else if (addr_free_s) begin
            if (replay_in_addr_r & addr_valid_r) begin
                replay_pending_r <= 1'b0;
                replay_in_addr_r <= 1'b0;
            end
            if (issue_replay_s) begin
                addr_valid_r     <= 1'b1;
                addr_write_r     <= rp_write_r;
                addr_size_r      <= rp_size_r;
                haddr_r          <= rp_addr_r;
                addr_wdata_r     <= rp_wdata_r;
                replay_in_addr_r <= 1'b1;
            end else if (accept_s) begin
                addr_valid_r <= 1'b1;
                addr_write_r <= bus.cmd_write;
                addr_size_r  <= norm_size(bus.cmd_size);
                haddr_r      <= align_addr(bus.cmd_addr, norm_size(bus.cmd_size));
                addr_wdata_r <= bus.cmd_wdata;
            end else begin
                addr_valid_r <= 1'b0;
            end
        end
    end

    // Data phase register: advances only when the bus is ready.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            data_valid_r <= 1'b0;
            data_write_r <= 1'b0;
            hwdata_r     <= {DATA_WIDTH{1'b0}};
        end else if (bus.HREADY) begin
            data_valid_r <= addr_valid_r;
            data_write_r <= addr_valid_r & addr_write_r;
            hwdata_r     <= (addr_valid_r & addr_write_r) ? addr_wdata_r : {DATA_WIDTH{1'b0}};
        end
    end

    // Response generation; a cancelled command answers one cycle after its predecessor.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rsp_valid_r      <= 1'b0;
            rsp_err_r        <= 1'b0;
            rsp_rdata_r      <= {DATA_WIDTH{1'b0}};
            cancel_pending_r <= 1'b0;
        end else begin
            if (data_valid_r & bus.HREADY) begin
                rsp_valid_r <= 1'b1;
                rsp_err_r   <= bus.HRESP;
                rsp_rdata_r <= (~data_write_r & ~bus.HRESP) ? bus.HRDATA : {DATA_WIDTH{1'b0}};
            end else if (cancel_pending_r) begin
                rsp_valid_r      <= 1'b1;
                rsp_err_r        <= 1'b1;
                rsp_rdata_r      <= {DATA_WIDTH{1'b0}};
                cancel_pending_r <= 1'b0;
            end else begin
                rsp_valid_r <= 1'b0;
                rsp_err_r   <= 1'b0;
                rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            end
            if (cancel_set_s) begin
                cancel_pending_r <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.HTRANS    = addr_valid_r ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HADDR     = haddr_r;
    assign bus.HWRITE    = addr_write_r;
    assign bus.HSIZE     = {1'b0, addr_size_r};
    assign bus.HBURST    = 3'b000;
    assign bus.HPROT     = HPROT_VAL;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.HWDATA    = hwdata_r;
endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed scoreboard bench for ahb_cmd_master: one instance with replay, one without.
module tb_ahb_cmd_master;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    exp_t exp0_q[$];

    always #5 clk = ~clk;

    ahb_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    ahb_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();

    ahb_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REPLAY_ON_ERROR(1), .HPROT_VAL(4'b0011))
        dut (.HCLK(clk), .HRESET(rst), .bus(bus.master));
    ahb_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REPLAY_ON_ERROR(0), .HPROT_VAL(4'b0011))
        dut0 (.HCLK(clk), .HRESET(rst), .bus(bus0.master));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cmd(input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic e_err, input logic [31:0] e_rd);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_size  = sz;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        exp_q.push_back('{err: e_err, rdata: e_rd});
    endtask

    // Scoreboard monitors: every response pulse pops and compares against the command order.
    always @(negedge clk) begin
        exp_t e;
        if (bus.rsp_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got err=%0b rdata=%h expected no response", bus.rsp_err, bus.rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                if (bus.rsp_err !== e.err || bus.rsp_rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL rsp: got err=%0b rdata=%h expected err=%0b rdata=%h",
                             bus.rsp_err, bus.rsp_rdata, e.err, e.rdata);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus0.rsp_valid === 1'b1) begin
            checks++;
            if (exp0_q.size() == 0) begin
                errors++;
                $display("FAIL rsp0_unexpected: got err=%0b rdata=%h expected no response", bus0.rsp_err, bus0.rsp_rdata);
            end else begin
                e = exp0_q.pop_front();
                if (bus0.rsp_err !== e.err || bus0.rsp_rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL rsp0: got err=%0b rdata=%h expected err=%0b rdata=%h",
                             bus0.rsp_err, bus0.rsp_rdata, e.err, e.rdata);
                end
            end
        end
    end

    initial begin
        bus.cmd_valid = 1'b0;  bus.cmd_write = 1'b0;  bus.cmd_size = 2'd0;
        bus.cmd_addr  = 32'd0; bus.cmd_wdata = 32'd0;
        bus.HREADY    = 1'b1;  bus.HRESP = 1'b0;      bus.HRDATA = 32'd0;
        bus0.cmd_valid = 1'b0;  bus0.cmd_write = 1'b0; bus0.cmd_size = 2'd0;
        bus0.cmd_addr  = 32'd0; bus0.cmd_wdata = 32'd0;
        bus0.HREADY    = 1'b1;  bus0.HRESP = 1'b0;     bus0.HRDATA = 32'd0;
        tick();
        tick();

        // Reset values
        chk("rst_htrans", 32'(bus.HTRANS), 32'd0);
        chk("rst_haddr", bus.HADDR, 32'd0);
        chk("rst_hwrite", 32'(bus.HWRITE), 32'd0);
        chk("rst_hsize", 32'(bus.HSIZE), 32'd0);
        chk("rst_hwdata", bus.HWDATA, 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("hburst", 32'(bus.HBURST), 32'd0);
        chk("hprot", 32'(bus.HPROT), 32'd3);
        chk("hmastlock", 32'(bus.HMASTLOCK), 32'd0);
        rst = 1'b0;
        tick();

        // Single write, zero wait states
        cmd(1'b1, 2'd2, 32'h10, 32'hA5A5_0001, 1'b0, 32'd0);
        #1 chk("t1_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        chk("t1_htrans", 32'(bus.HTRANS), 32'd2);
        chk("t1_haddr", bus.HADDR, 32'h10);
        chk("t1_hwrite", 32'(bus.HWRITE), 32'd1);
        chk("t1_hsize", 32'(bus.HSIZE), 32'd2);
        tick();
        chk("t1_htrans_idle", 32'(bus.HTRANS), 32'd0);
        chk("t1_hwdata", bus.HWDATA, 32'hA5A5_0001);
        chk("t1_rsp_early", 32'(bus.rsp_valid), 32'd0);
        tick();
        chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("t1_hwdata_idle", bus.HWDATA, 32'd0);
        tick();

        // Four back-to-back reads returning 1..4
        for (int i = 0; i <= 6; i++) begin
            if (i < 4) begin
                cmd(1'b0, 2'd2, 32'h40 + 32'(4 * i), 32'd0, 1'b0, 32'(i + 1));
                #1 chk("t2_cmd_ready", 32'(bus.cmd_ready), 32'd1);
            end else begin
                bus.cmd_valid = 1'b0;
            end
            bus.HRDATA = (i >= 2 && i <= 5) ? 32'(i - 1) : 32'd0;
            if (i >= 1 && i <= 4) begin
                chk("t2_htrans", 32'(bus.HTRANS), 32'd2);
                chk("t2_haddr", bus.HADDR, 32'h40 + 32'(4 * (i - 1)));
            end
            if (i >= 3) chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            tick();
        end
        tick();

        // Halfword write (misaligned address) stalled 3 cycles with a read in its address phase
        cmd(1'b1, 2'd1, 32'h31, 32'h1234_5678, 1'b0, 32'd0);
        tick();
        cmd(1'b0, 2'd3, 32'h36, 32'd0, 1'b0, 32'hCAFE_0001);
        chk("t3_haddr_align", bus.HADDR, 32'h30);
        chk("t3_hsize", 32'(bus.HSIZE), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        bus.HREADY    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            chk("t3_hwdata", bus.HWDATA, 32'h1234_5678);
            chk("t3_haddr", bus.HADDR, 32'h34);
            chk("t3_htrans", 32'(bus.HTRANS), 32'd2);
            tick();
        end
        bus.HREADY = 1'b1;
        chk("t3_haddr_end", bus.HADDR, 32'h34);
        chk("t3_hsize_word", 32'(bus.HSIZE), 32'd2);
        chk("t3_no_rsp", 32'(bus.rsp_valid), 32'd0);
        tick();
        bus.HRDATA = 32'hCAFE_0001;
        chk("t3_rsp_write", 32'(bus.rsp_valid), 32'd1);
        chk("t3_hwdata_read", bus.HWDATA, 32'd0);
        tick();
        bus.HRDATA = 32'd0;
        chk("t3_rsp_read", 32'(bus.rsp_valid), 32'd1);
        tick();

        // ERROR on write 0x20 while read 0x24 is in address phase, with replay
        cmd(1'b1, 2'd2, 32'h20, 32'h0BAD_0020, 1'b1, 32'd0);
        tick();
        cmd(1'b0, 2'd2, 32'h24, 32'd0, 1'b0, 32'h0000_0024);
        tick();
        bus.cmd_valid = 1'b0;
        bus.HREADY = 1'b0;
        bus.HRESP  = 1'b1;
        #1 chk("t4_cmd_ready_err1", 32'(bus.cmd_ready), 32'd0);
        chk("t4_htrans_err1", 32'(bus.HTRANS), 32'd2);
        chk("t4_haddr_err1", bus.HADDR, 32'h24);
        tick();
        bus.HREADY = 1'b1;
        bus.HRDATA = 32'hDEAD_BEEF;
        chk("t4_htrans_idle", 32'(bus.HTRANS), 32'd0);
        #1 chk("t4_cmd_ready_err2", 32'(bus.cmd_ready), 32'd0);
        tick();
        bus.HRESP  = 1'b0;
        bus.HRDATA = 32'd0;
        chk("t4_rsp_err", 32'(bus.rsp_valid), 32'd1);
        chk("t4_replay_htrans", 32'(bus.HTRANS), 32'd2);
        chk("t4_replay_haddr", bus.HADDR, 32'h24);
        chk("t4_replay_hwrite", 32'(bus.HWRITE), 32'd0);
        cmd(1'b0, 2'd2, 32'h28, 32'd0, 1'b0, 32'h0000_0028);
        #1 chk("t4_cmd_ready_replay", 32'(bus.cmd_ready), 32'd0);
        tick();
        bus.HRDATA = 32'h0000_0024;
        chk("t4_htrans_after", 32'(bus.HTRANS), 32'd0);
        #1 chk("t4_cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        bus.HRDATA = 32'd0;
        chk("t4_next_haddr", bus.HADDR, 32'h28);
        tick();
        bus.HRDATA = 32'h0000_0028;
        tick();
        bus.HRDATA = 32'd0;
        tick();

        // Same ERROR scenario without replay: both commands answered with error
        bus0.cmd_valid = 1'b1; bus0.cmd_write = 1'b1; bus0.cmd_size = 2'd2;
        bus0.cmd_addr = 32'h20; bus0.cmd_wdata = 32'h0BAD_0020;
        exp0_q.push_back('{err: 1'b1, rdata: 32'd0});
        tick();
        bus0.cmd_write = 1'b0; bus0.cmd_addr = 32'h24;
        exp0_q.push_back('{err: 1'b1, rdata: 32'd0});
        tick();
        bus0.cmd_valid = 1'b0;
        bus0.HREADY = 1'b0;
        bus0.HRESP  = 1'b1;
        bus0.HRDATA = 32'hFFFF_FFFF;
        chk("t5_htrans_err1", 32'(bus0.HTRANS), 32'd2);
        tick();
        bus0.HREADY = 1'b1;
        chk("t5_htrans_idle", 32'(bus0.HTRANS), 32'd0);
        #1 chk("t5_cmd_ready", 32'(bus0.cmd_ready), 32'd1);
        tick();
        bus0.HRESP = 1'b0;
        chk("t5_rsp1", 32'(bus0.rsp_valid), 32'd1);
        chk("t5_htrans_idle2", 32'(bus0.HTRANS), 32'd0);
        tick();
        chk("t5_rsp2", 32'(bus0.rsp_valid), 32'd1);
        chk("t5_htrans_idle3", 32'(bus0.HTRANS), 32'd0);
        tick();
        bus0.HRDATA = 32'd0;
        chk("t5_rsp_done", 32'(bus0.rsp_valid), 32'd0);
        tick();

        // HRESP with HREADY high and no first error cycle
        cmd(1'b0, 2'd2, 32'h60, 32'd0, 1'b1, 32'd0);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        bus.HRESP  = 1'b1;
        bus.HRDATA = 32'h77;
        tick();
        bus.HRESP  = 1'b0;
        bus.HRDATA = 32'd0;
        chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        tick();

        // Reset during a wait-stated write data phase: no response expected
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_size = 2'd2;
        bus.cmd_addr = 32'h50; bus.cmd_wdata = 32'h5555_5555;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        bus.HREADY = 1'b0;
        chk("t7_hwdata", bus.HWDATA, 32'h5555_5555);
        tick();
        rst = 1'b1;
        tick();
        chk("t7_htrans", 32'(bus.HTRANS), 32'd0);
        chk("t7_hwdata_rst", bus.HWDATA, 32'd0);
        chk("t7_haddr_rst", bus.HADDR, 32'd0);
        chk("t7_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        #1 chk("t7_cmd_ready_in_rst", 32'(bus.cmd_ready), 32'd0);
        rst = 1'b0;
        bus.HREADY = 1'b1;
        #1 chk("t7_cmd_ready_release", 32'(bus.cmd_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t7_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end

        for (int k = 0; k < 20 && (exp_q.size() != 0 || exp0_q.size() != 0); k++) tick();
        checks++;
        if (exp_q.size() != 0 || exp0_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d responses outstanding expected 0/0", exp_q.size(), exp0_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
